pong_ball_engine: RTL

- Parametrised successor to the single-ball pong graphics/animation block: owns paddle position, ball motion FSM, collision detection and pixel colour generation for one playfield.
- Sits between the HDMI/VGA timing generator (pix_x, pix_y, video_on) and the TMDS encoder front end; all motion updates once per frame.
- Adds over the previous generation: configurable geometry/speeds, round/square ball mode, explicit launch/miss handling, hit/miss event pulses and counters.

---
 rtl/pong_pkg.sv | 44 ++++
 rtl/pong_ball_engine_if.sv | 29 ++
 rtl/pong_ball_rom.sv | 13 +
 rtl/pong_ball_engine.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball engine: FSM state encoding, colour
// constants, ball geometry and small direction helpers.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_UL   = 3'b001,
    ST_UR   = 3'b010,
    ST_DR   = 3'b011,
    ST_DL   = 3'b100,
    ST_MISS = 3'b111
  } ball_state_e;

  localparam logic [2:0] RGB_BLANK = 3'b000;
  localparam logic [2:0] RGB_WALL  = 3'b001;
  localparam logic [2:0] RGB_BAR   = 3'b010;
  localparam logic [2:0] RGB_BALL  = 3'b100;
  localparam logic [2:0] RGB_BG    = 3'b110;

  localparam int BALL_SIZE = 8;

  function automatic logic is_moving(ball_state_e s);
    return s inside {ST_UL, ST_UR, ST_DR, ST_DL};
  endfunction

  function automatic logic goes_right(ball_state_e s);
    return s inside {ST_UR, ST_DR};
  endfunction

  function automatic logic goes_down(ball_state_e s);
    return s inside {ST_DR, ST_DL};
  endfunction

  // Rebuild a moving state from its horizontal and vertical components.
  function automatic ball_state_e dir_state(logic right, logic down);
    case ({right, down})
      2'b00:   return ST_UL;
      2'b10:   return ST_UR;
      2'b11:   return ST_DR;
      default: return ST_DL;
    endcase
  endfunction

endpackage

// File: rtl/pong_ball_engine_if.sv
// Pixel-side bundle of the pong ball engine: scan position and controls in,
// pixel colour, events and counters out.
interface pong_ball_engine_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 8
);
  logic               video_on;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [1:0]         btn;
  logic               launch;
  logic               ball_round;
  logic [2:0]         graph_rgb;
  logic               ball_hit;
  logic               ball_miss;
  logic [CNT_W-1:0]   hit_count;
  logic [CNT_W-1:0]   miss_count;
  logic               game_active;

  modport master (
    output video_on, pix_x, pix_y, btn, launch, ball_round,
    input  graph_rgb, ball_hit, ball_miss, hit_count, miss_count, game_active
  );

  modport slave (
    input  video_on, pix_x, pix_y, btn, launch, ball_round,
    output graph_rgb, ball_hit, ball_miss, hit_count, miss_count, game_active
  );
endinterface

// File: rtl/pong_ball_rom.sv
// Round-ball mask: one 8-bit row per ball line, MSB is the leftmost pixel.
module pong_ball_rom (
  input  logic [2:0] row_i,
  output logic [7:0] mask_o
);
  always_comb begin
    case (row_i)
      3'd0, 3'd7: mask_o = 8'h3C;
      3'd1, 3'd6: mask_o = 8'h7E;
      default:    mask_o = 8'hFF;
    endcase
  end
endmodule

// File: rtl/pong_ball_engine.sv
// Single-playfield pong engine: paddle, ball motion FSM, collisions, event
// counters and registered pixel colour. Motion advances once per frame.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int WALL_X_L   = 32,
  parameter int WALL_X_R   = 35,
  parameter int BAR_X_L    = 600,
  parameter int BAR_X_R    = 603,
  parameter int BAR_Y_SIZE = 72,
  parameter int BAR_V      = 4,
  parameter int BALL_V     = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  pong_ball_engine_if.slave bus
);

  localparam logic [COORD_W-1:0] TICK_Y       = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] BAR_Y_RST    = COORD_W'((V_ACTIVE - BAR_Y_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_X_CTR   = COORD_W'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [COORD_W-1:0] BALL_Y_CTR   = COORD_W'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [COORD_W-1:0] BAR_EXT      = COORD_W'(BAR_Y_SIZE - 1);
  localparam logic [COORD_W-1:0] BALL_EXT     = COORD_W'(BALL_SIZE - 1);
  localparam logic [COORD_W-1:0] BAR_STEP     = COORD_W'(BAR_V);
  localparam logic [COORD_W-1:0] BALL_STEP    = COORD_W'(BALL_V);
  // Paddle may step down only while its top stays below this row.
  localparam logic [COORD_W-1:0] BAR_DOWN_LIM = COORD_W'(V_ACTIVE - 1 - BAR_V - (BAR_Y_SIZE - 1));
  localparam logic [COORD_W-1:0] TOP_LIM      = COORD_W'(BALL_V);
  localparam logic [COORD_W-1:0] BOT_LIM      = COORD_W'(V_ACTIVE - 1 - BALL_V);
  localparam logic [COORD_W-1:0] WALL_LIM     = COORD_W'(WALL_X_R + BALL_V);
  localparam logic [COORD_W-1:0] MISS_LIM     = COORD_W'(H_ACTIVE - 1 - BALL_V);
  localparam logic [COORD_W-1:0] WALL_L       = COORD_W'(WALL_X_L);
  localparam logic [COORD_W-1:0] WALL_R       = COORD_W'(WALL_X_R);
  localparam logic [COORD_W-1:0] BAR_L        = COORD_W'(BAR_X_L);
  localparam logic [COORD_W-1:0] BAR_R        = COORD_W'(BAR_X_R);

  ball_state_e        state_q, state_d;
  logic [COORD_W-1:0] bar_y_q, bar_y_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d;
  logic [COORD_W-1:0] ball_y_q, ball_y_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               game_active_q;
  logic [2:0]         rgb_q, rgb_d;

  logic               refr_tick;
  logic [COORD_W-1:0] bar_y_b, ball_x_r, ball_y_b;
  logic               go_right, go_down;
  logic               flip_v, flip_wall, paddle_hit, exit_right, flip_h;

  assign refr_tick = (bus.pix_x == '0) && (bus.pix_y == TICK_Y);
  assign bar_y_b   = bar_y_q + BAR_EXT;
  assign ball_x_r  = ball_x_q + BALL_EXT;
  assign ball_y_b  = ball_y_q + BALL_EXT;

  // Collision flags from current positions; only consulted in moving states.
  assign go_right   = goes_right(state_q);
  assign go_down    = goes_down(state_q);
  assign flip_v     = go_down ? (ball_y_b >= BOT_LIM) : (ball_y_q <= TOP_LIM);
  assign flip_wall  = !go_right && (ball_x_q <= WALL_LIM);
  assign paddle_hit = go_right && (ball_x_r >= BAR_L) && (ball_x_r <= BAR_R)
                      && (ball_y_b >= bar_y_q) && (ball_y_q <= bar_y_b);
  assign exit_right = go_right && !paddle_hit && (ball_x_r >= MISS_LIM);
  assign flip_h     = flip_wall || paddle_hit;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bar_y_d    = bar_y_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    if (refr_tick) begin
      if (bus.btn == 2'b10 && bar_y_q < BAR_DOWN_LIM) begin
        bar_y_d = bar_y_q + BAR_STEP;
      end else if (bus.btn == 2'b01 && bar_y_q > BAR_STEP) begin
        bar_y_d = bar_y_q - BAR_STEP;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (bus.launch) state_d = ST_UL;
        end
        ST_MISS: begin
          if (bus.launch) begin
            ball_x_d = BALL_X_CTR;
            ball_y_d = BALL_Y_CTR;
            state_d  = ST_UL;
          end
        end
        default: begin
          if (exit_right) begin
            state_d = ST_MISS;
            miss_d  = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end else if (flip_v || flip_h) begin
            // A bounce replaces this frame's step.
            state_d = dir_state(go_right ^ flip_h, go_down ^ flip_v);
            hit_d   = paddle_hit;
            if (paddle_hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            ball_x_d = go_right ? ball_x_q + BALL_STEP : ball_x_q - BALL_STEP;
            ball_y_d = go_down  ? ball_y_q + BALL_STEP : ball_y_q - BALL_STEP;
          end
        end
      endcase
    end
  end

  logic       wall_on, bar_on, ball_sq, ball_on;
  logic [2:0] ball_row, ball_col;
  logic [7:0] ball_mask;

  assign ball_row = 3'(bus.pix_y - ball_y_q);
  assign ball_col = 3'(bus.pix_x - ball_x_q);

  pong_ball_rom u_rom (
    .row_i  (ball_row),
    .mask_o (ball_mask)
  );

  assign wall_on = (bus.pix_x >= WALL_L) && (bus.pix_x <= WALL_R);
  assign bar_on  = (bus.pix_x >= BAR_L) && (bus.pix_x <= BAR_R)
                   && (bus.pix_y >= bar_y_q) && (bus.pix_y <= bar_y_b);
  assign ball_sq = (bus.pix_x >= ball_x_q) && (bus.pix_x <= ball_x_r)
                   && (bus.pix_y >= ball_y_q) && (bus.pix_y <= ball_y_b);
  assign ball_on = ball_sq && (state_q != ST_MISS)
                   && (!bus.ball_round || ball_mask[~ball_col]);

  always_comb begin
    rgb_d = RGB_BG;
    if (!bus.video_on)  rgb_d = RGB_BLANK;
    else if (wall_on)   rgb_d = RGB_WALL;
    else if (bar_on)    rgb_d = RGB_BAR;
    else if (ball_on)   rgb_d = RGB_BALL;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bar_y_q       <= BAR_Y_RST;
      ball_x_q      <= BALL_X_CTR;
      ball_y_q      <= BALL_Y_CTR;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      game_active_q <= 1'b0;
      rgb_q         <= RGB_BLANK;
    end else begin
      state_q       <= state_d;
      bar_y_q       <= bar_y_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      game_active_q <= is_moving(state_d);
      rgb_q         <= rgb_d;
    end
  end

  assign bus.graph_rgb   = rgb_q;
  assign bus.ball_hit    = hit_q;
  assign bus.ball_miss   = miss_q;
  assign bus.hit_count   = hit_cnt_q;
  assign bus.miss_count  = miss_cnt_q;
  assign bus.game_active = game_active_q;

endmodule
